// File: rtl/intr_request_ctrl.sv
// Interrupt request controller: synchronises and edge-detects external pins, latches
// masked pending bits, and drives a fixed-priority INTR handshake with the control unit.
module intr_request_ctrl #(
    parameter int unsigned           NUM_SRC  = 4,
    parameter int unsigned           ID_W     = 2,
    parameter logic [NUM_SRC-1:0]    MASK_RST = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               int_ack,
    input  logic               rti_done,
    input  logic               mask_wr,
    input  logic [NUM_SRC-1:0] mask_data,
    output logic               INTR,
    output logic [ID_W-1:0]    irq_id,
    output logic               in_service,
    output logic [NUM_SRC-1:0] pending
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        SERVICE = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic               intr_q, intr_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic               in_service_q, in_service_d;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr_oh;
    logic [ID_W-1:0]    winner;

    assign rise     = sync2_q & ~prev_q;
    assign eligible = pending_q & ~mask_q;
    assign mask_d   = mask_wr ? mask_data : mask_q;

    // Set is OR'ed in after the clear so a fresh edge in the ack cycle is kept.
    assign pending_d = (pending_q & ~clr_oh) | rise;

    always_comb begin
        winner = '0;
        for (int unsigned i = NUM_SRC; i > 0; i--) begin
            if (eligible[i-1]) begin
                winner = ID_W'(i - 1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        intr_d       = intr_q;
        irq_id_d     = irq_id_q;
        in_service_d = in_service_q;
        clr_oh       = '0;
        case (state_q)
            IDLE: begin
                intr_d       = 1'b0;
                in_service_d = 1'b0;
                if (|eligible) begin
                    irq_id_d = winner;
                    intr_d   = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                intr_d = 1'b1;
                if (int_ack) begin
                    for (int unsigned i = 0; i < NUM_SRC; i++) begin
                        if (irq_id_q == ID_W'(i)) begin
                            clr_oh[i] = 1'b1;
                        end
                    end
                    intr_d       = 1'b0;
                    in_service_d = 1'b1;
                    state_d      = SERVICE;
                end
            end
            SERVICE: begin
                intr_d       = 1'b0;
                in_service_d = 1'b1;
                if (rti_done) begin
                    in_service_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                intr_d       = 1'b0;
                in_service_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            pending_q    <= '0;
            mask_q       <= MASK_RST;
            state_q      <= IDLE;
            intr_q       <= 1'b0;
            irq_id_q     <= '0;
            in_service_q <= 1'b0;
        end else begin
            sync1_q      <= irq_in;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            state_q      <= state_d;
            intr_q       <= intr_d;
            irq_id_q     <= irq_id_d;
            in_service_q <= in_service_d;
        end
    end

    assign INTR       = intr_q;
    assign irq_id     = irq_id_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_intr_request_ctrl.sv
// Directed bench for intr_request_ctrl: expected request ids are queued by the stimulus
// and popped by a monitor on each INTR rise; status outputs are checked inline.
module tb_intr_request_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] irq_in;
    logic       int_ack;
    logic       rti_done;
    logic       mask_wr;
    logic [3:0] mask_data;
    logic       INTR;
    logic [1:0] irq_id;
    logic       in_service;
    logic [3:0] pending;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [1:0]  exp_q[$];

    intr_request_ctrl #(
        .NUM_SRC (4),
        .ID_W    (2),
        .MASK_RST(4'b0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .int_ack   (int_ack),
        .rti_done  (rti_done),
        .mask_wr   (mask_wr),
        .mask_data (mask_data),
        .INTR      (INTR),
        .irq_id    (irq_id),
        .in_service(in_service),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    // Drive a one-cycle pin pulse, then wait until the edge that sets pending.
    task automatic pulse_irq(input logic [3:0] v);
        irq_in = v;
        step();
        irq_in = '0;
        steps(2);
    endtask

    task automatic ack();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
    endtask

    task automatic rti();
        rti_done = 1'b1;
        step();
        rti_done = 1'b0;
    endtask

    // Monitor: every new INTR assertion must match the next queued id.
    initial begin
        logic       intr_prev;
        logic [1:0] e;
        intr_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && INTR && !intr_prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got INTR with irq_id %0d expected no request", irq_id);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_irq_id", 32'(irq_id), 32'(e));
                end
            end
            intr_prev = INTR;
        end
    end

    initial begin
        #100000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        irq_in    = '0;
        int_ack   = 1'b0;
        rti_done  = 1'b0;
        mask_wr   = 1'b0;
        mask_data = '0;
        steps(3);
        rst = 1'b1;
        chk("rst_INTR", 32'(INTR), 0);
        chk("rst_irq_id", 32'(irq_id), 0);
        chk("rst_in_service", 32'(in_service), 0);
        chk("rst_pending", 32'(pending), 0);

        // 1: single source, 3-edge pending latency and held request
        exp_q.push_back(2'd2);
        pulse_irq(4'b0100);
        chk("t1_pending", 32'(pending), 32'h4);
        chk("t1_INTR_early", 32'(INTR), 0);
        step();
        chk("t1_INTR", 32'(INTR), 1);
        chk("t1_irq_id", 32'(irq_id), 2);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t1_INTR_held", 32'(INTR), 1);
        end

        // 2: ack and RTI
        ack();
        chk("t2_INTR", 32'(INTR), 0);
        chk("t2_in_service", 32'(in_service), 1);
        chk("t2_pending", 32'(pending), 0);
        rti();
        chk("t2_in_service_off", 32'(in_service), 0);
        steps(3);
        chk("t2_INTR_idle", 32'(INTR), 0);

        // 3: priority, then re-request two cycles after rti_done
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        pulse_irq(4'b1010);
        chk("t3_pending", 32'(pending), 32'hA);
        step();
        chk("t3_irq_id_first", 32'(irq_id), 1);
        ack();
        chk("t3_pending_after_ack", 32'(pending), 32'h8);
        rti();
        chk("t3_INTR_gap", 32'(INTR), 0);
        step();
        chk("t3_INTR_rereq", 32'(INTR), 1);
        chk("t3_irq_id_second", 32'(irq_id), 3);
        ack();
        rti();

        // 4: masked source latches pending, fires after unmask
        mask_data = 4'b0001;
        mask_wr   = 1'b1;
        step();
        mask_wr = 1'b0;
        pulse_irq(4'b0001);
        steps(2);
        chk("t4_pending_masked", 32'(pending), 32'h1);
        chk("t4_INTR_masked", 32'(INTR), 0);
        exp_q.push_back(2'd0);
        mask_data = 4'b0000;
        mask_wr   = 1'b1;
        step();
        mask_wr = 1'b0;
        chk("t4_INTR_write_edge", 32'(INTR), 0);
        step();
        chk("t4_INTR_unmasked", 32'(INTR), 1);
        chk("t4_irq_id", 32'(irq_id), 0);
        ack();
        rti();

        // 5: no nesting, stray ack ignored, ack+rti together
        exp_q.push_back(2'd2);
        pulse_irq(4'b0100);
        step();
        ack();
        pulse_irq(4'b0001);
        ack();
        chk("t5_INTR_nonest", 32'(INTR), 0);
        chk("t5_in_service", 32'(in_service), 1);
        chk("t5_pending_kept", 32'(pending), 32'h1);
        exp_q.push_back(2'd0);
        rti();
        chk("t5_INTR_gap", 32'(INTR), 0);
        step();
        chk("t5_INTR_src0", 32'(INTR), 1);
        chk("t5_irq_id", 32'(irq_id), 0);
        int_ack  = 1'b1;
        rti_done = 1'b1;
        step();
        int_ack  = 1'b0;
        rti_done = 1'b0;
        chk("t5_both_in_service", 32'(in_service), 1);
        chk("t5_both_INTR", 32'(INTR), 0);
        rti();

        // 6: synchronous reset in REQ; glitch between edges has no effect
        exp_q.push_back(2'd3);
        pulse_irq(4'b1000);
        step();
        mask_data = 4'b1111;
        mask_wr   = 1'b1;
        step();
        mask_wr = 1'b0;
        chk("t6_INTR_masked_in_req", 32'(INTR), 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("t6_INTR", 32'(INTR), 0);
        chk("t6_in_service", 32'(in_service), 0);
        chk("t6_pending", 32'(pending), 0);
        exp_q.push_back(2'd1);
        pulse_irq(4'b0010);
        step();
        chk("t6_mask_reset_INTR", 32'(INTR), 1);
        chk("t6_irq_id", 32'(irq_id), 1);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        step();
        chk("t6_glitch_INTR", 32'(INTR), 1);
        ack();
        rti();
        steps(2);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d queued expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
